// File: rtl/line_mirror_pingpong_buf_if.sv
// Beat-write and pixel-read handshake bundle for the ping-pong line buffer.
// The master side is the DDR reader plus timing generator; the slave side is the buffer.
interface line_mirror_pingpong_buf_if #(
  parameter int PIX_W        = 16,
  parameter int PIX_PER_BEAT = 16
) ();
  logic                          wr_en;
  logic [PIX_W*PIX_PER_BEAT-1:0] wr_data;
  logic                          wr_ready;
  logic                          line_req;
  logic                          rd_en;
  logic                          de_o;
  logic [PIX_W-1:0]              pix_o;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, line_req, de_o, pix_o
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, line_req, de_o, pix_o
  );
endinterface

// File: rtl/line_mirror_pingpong_buf.sv
// Two-bank line buffer: stores wide DDR beats and replays each line one pixel
// per clock, forward or mirrored, with masking, flow control and error flags.
module line_mirror_pingpong_buf #(
  parameter int PIX_W        = 16,
  parameter int PIX_PER_BEAT = 16,
  parameter int LINE_PIX     = 1280,
  parameter int LINES        = 720,
  parameter int MASK_X_START = 1280,
  parameter int MASK_Y_END   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fsync,
  input  logic                       mirror_en,
  line_mirror_pingpong_buf_if.slave  bus,
  output logic [$clog2(LINES)-1:0]   row_cnt,
  output logic                       ovf_err,
  output logic                       udr_err
);
  localparam int BEATS = LINE_PIX / PIX_PER_BEAT;
  localparam int BW    = PIX_W * PIX_PER_BEAT;
  localparam int WC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MA_W  = $clog2(2 * BEATS);
  localparam int P_W   = $clog2(LINE_PIX + 1);
  localparam int A_W   = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam int L_W   = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int RW    = $clog2(LINES);

  localparam logic [P_W-1:0]  P_END    = P_W'(LINE_PIX);
  localparam logic [P_W-1:0]  MASK_X   = P_W'(MASK_X_START);
  localparam logic [RW:0]     MASK_Y   = (RW+1)'(MASK_Y_END);
  localparam logic [RW-1:0]   ROW_LAST = RW'(LINES - 1);
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(BEATS - 1);

  typedef enum logic [1:0] {R_IDLE, R_LINE, R_UDR} rd_state_e;

  logic [BW-1:0]   mem [2*BEATS];
  logic            fsync_q, rd_q, fs_rise, rd_rise, rd_fall;
  logic [1:0]      full, full_d;
  logic            wb, rb, mir, req2;
  logic [WC_W-1:0] wcnt, rbeat;
  logic [P_W-1:0]  p_q, p_cur;
  logic [A_W-1:0]  p_a, addr;
  logic [L_W-1:0]  lane, lane_q;
  logic [MA_W-1:0] wa, ra;
  logic [BW-1:0]   beat_q;
  logic            wr_acc, wr_done, pix_ok, pix_ok_q;
  logic            line_act, rel, row_adv, udr_set;
  rd_state_e       state_q, state_d;

  assign fs_rise = fsync & ~fsync_q;
  assign rd_rise = bus.rd_en & ~rd_q;
  assign rd_fall = ~bus.rd_en & rd_q;

  assign bus.wr_ready = rst & ~full[wb];
  assign wr_acc  = bus.wr_en & bus.wr_ready & ~fs_rise;
  assign wr_done = wr_acc & (wcnt == WC_LAST);
  assign wa = wb ? MA_W'(BEATS) + MA_W'(wcnt) : MA_W'(wcnt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= R_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (fs_rise) state_d = R_IDLE;
    else begin
      case (state_q)
        R_IDLE:         if (rd_rise) state_d = full[rb] ? R_LINE : R_UDR;
        R_LINE, R_UDR:  if (rd_fall) state_d = R_IDLE;
        default:        state_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    line_act = 1'b0;
    rel      = 1'b0;
    row_adv  = 1'b0;
    udr_set  = 1'b0;
    if (!fs_rise) begin
      case (state_q)
        R_IDLE: begin
          line_act = rd_rise & full[rb];
          udr_set  = rd_rise & ~full[rb];
        end
        R_LINE: begin
          line_act = bus.rd_en;
          rel      = rd_fall;
          row_adv  = rd_fall;
        end
        R_UDR:   row_adv = rd_fall;
        default: ;
      endcase
    end
  end

  // Mask column is the output position, not the mirrored fetch address.
  always_comb begin
    p_cur  = rd_rise ? '0 : p_q;
    p_a    = p_cur[A_W-1:0];
    addr   = mir ? A_W'(LINE_PIX - 1) - p_a : p_a;
    rbeat  = WC_W'(addr / A_W'(PIX_PER_BEAT));
    lane   = L_W'(addr % A_W'(PIX_PER_BEAT));
    ra     = rb ? MA_W'(BEATS) + MA_W'(rbeat) : MA_W'(rbeat);
    pix_ok = line_act && (p_cur != P_END) &&
             !((p_cur >= MASK_X) && ({1'b0, row_cnt} < MASK_Y));
  end

  always_comb begin
    full_d = full;
    if (wr_done) full_d[wb] = 1'b1;
    if (rel)     full_d[rb] = 1'b0;
  end

  // NOTE: line RAM and its read register carry no reset; the full flags guard stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wa] <= bus.wr_data;
    beat_q <= mem[ra];
    lane_q <= lane;
  end

  assign bus.pix_o = pix_ok_q ? beat_q[lane_q*PIX_W +: PIX_W] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsync_q      <= 1'b0;
      rd_q         <= 1'b0;
      full         <= '0;
      wb           <= 1'b0;
      rb           <= 1'b0;
      wcnt         <= '0;
      p_q          <= '0;
      row_cnt      <= '0;
      mir          <= 1'b0;
      req2         <= 1'b0;
      ovf_err      <= 1'b0;
      udr_err      <= 1'b0;
      bus.line_req <= 1'b0;
      bus.de_o     <= 1'b0;
      pix_ok_q     <= 1'b0;
    end else begin
      fsync_q  <= fsync;
      rd_q     <= bus.rd_en;
      bus.de_o <= bus.rd_en;
      pix_ok_q <= pix_ok;
      if (bus.wr_en && !bus.wr_ready) ovf_err <= 1'b1;
      if (udr_set) udr_err <= 1'b1;
      if (fs_rise) begin
        // Two back-to-back requests prefetch both banks for the new frame.
        full         <= '0;
        wb           <= 1'b0;
        rb           <= 1'b0;
        wcnt         <= '0;
        p_q          <= '0;
        row_cnt      <= '0;
        mir          <= mirror_en;
        bus.line_req <= 1'b1;
        req2         <= 1'b1;
      end else begin
        full         <= full_d;
        bus.line_req <= req2 | row_adv;
        req2         <= 1'b0;
        if (wr_acc) begin
          wcnt <= wr_done ? '0 : wcnt + 1'b1;
          if (wr_done) wb <= ~wb;
        end
        if (rel) rb <= ~rb;
        if (row_adv) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        if (bus.rd_en) p_q <= (p_cur == P_END) ? p_cur : p_cur + 1'b1;
      end
    end
  end
endmodule
